stm_drive_mixer: RTL and testbench
==================================

Name: stm_drive_mixer

Overview:
- Downstream consumer of the STM stage's per-transducer stream (intensity, phase, valid burst of DEPTH samples per UPDATE).
- Scales intensity by the current modulation value and captures each burst into a ping-pong buffer indexed by transducer.
- Swaps banks on the next UPDATE so the PWM stage reads a stable, complete frame by index.

Parameters:
- DEPTH, 249, transducers per burst and entries per bank (1..256).
- MOD_LATENCY, 2, pipeline stages between DIN_VALID and the buffer write (fixed 2; 1 is not supported).

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- UPDATE  in  1  one-cycle pulse from time_cnt_generator; frame boundary.
- MOD  in  8  modulation value; sampled with the first valid sample of each burst.
- DIN_VALID  in  1  STM output valid.
- INTENSITY_IN  in  8  STM intensity.
- PHASE_IN  in  8  STM phase.
- RD_IDX  in  8  transducer index read by the PWM stage.
- INTENSITY_OUT  out  8  scaled intensity at RD_IDX from the read bank.
- PHASE_OUT  out  8  phase at RD_IDX from the read bank.
- OUT_READY  out  1  high once a complete frame has been swapped in.
- RD_BANK  out  1  bank currently being read.
- OVERRUN  out  1  sticky: a valid sample arrived after DEPTH samples in one frame.
- UNDERRUN  out  1  sticky: UPDATE arrived before the write frame was complete.

Behaviour:
- Reset values: INTENSITY_OUT=0, PHASE_OUT=0, OUT_READY=0, RD_BANK=0, OVERRUN=0, UNDERRUN=0.
- Reset clears the write counter (wr_cnt) and the pipeline valid bits; RAM contents are not cleared.
- Write bank = ~RD_BANK.
- Stage 0, on DIN_VALID:
  - If wr_cnt==0, latch mod_q=MOD and use MOD directly for this sample; otherwise use mod_q.
  - Register the intensity, phase, address=wr_cnt, and the modulation value in use.
  - Increment wr_cnt.
- Stage 1:
  - p = intensity*mod (16 bit unsigned).
  - scaled = (p + (p>>8) + 1) >> 8, truncated to 8 bits.
  - This equals floor(I*M/255) for all inputs. Exact values: 255,255->255; 128,255->128; x,0->0.
- Stage 2: write {scaled, phase} to the write bank at the captured address.
- Write latency: 2 cycles from DIN_VALID to the RAM write. Throughput: 1 sample per cycle.
- DIN_VALID while wr_cnt==DEPTH: sample dropped, no write, OVERRUN<=1.
- UPDATE handling:
  - If wr_cnt==DEPTH and no write is in flight in stages 1-2: RD_BANK<=~RD_BANK, OUT_READY<=1, wr_cnt<=0.
  - If wr_cnt==DEPTH but writes are in flight: the swap is deferred until the pipeline drains (at most 2 cycles). The new frame's valid samples are still accepted into the new write bank.
  - If wr_cnt!=DEPTH: no swap, UNDERRUN<=1, wr_cnt<=0. The partial frame is discarded by being overwritten.
- Simultaneous UPDATE and DIN_VALID: UPDATE is processed first. The sample becomes index 0 of the frame that follows the swap decision (wr_cnt=1 after the cycle), and MOD is latched.
- Read port: registered 1-cycle latency. INTENSITY_OUT/PHASE_OUT reflect RD_IDX and RD_BANK of the previous cycle.
- While OUT_READY==0, both outputs are forced to 0.
- RD_IDX >= DEPTH returns 0 on both outputs.
- RST asserted mid-burst: the burst is abandoned. After reset, a fresh frame plus UPDATE is required before OUT_READY rises.

Optional Feature:
- Macro: STM_DRIVE_MIXER_PHASE_CORR_EN.
- When defined, three extra ports are added:
  - PC_WE  in  1
  - PC_ADDR  in  8
  - PC_DATA  in  8
- These write a DEPTH-entry phase-offset table; a write takes effect on the next stage-0 read.
- Stage 1 then stores phase = PHASE_IN + offset[addr], mod 256. Total latency is unchanged.
- The offset table is not reset; the bench writes it before use.
- When not defined: the ports are absent and the phase passes through unchanged.

Test Plan:
- Reset, then 249 valid samples with I=255, P=idx, MOD=255, then UPDATE -> OUT_READY=1, RD_BANK=1. RD_IDX=10 gives INTENSITY_OUT=255 and PHASE_OUT=10 one cycle later.
- MOD=128 latched at sample 0, MOD changed to 0 mid-burst, I=200 -> all entries read 100 (floor(200*128/255)).
- UPDATE after only 100 samples -> UNDERRUN=1, RD_BANK unchanged, OUT_READY stays 0 if no prior frame.
- 250 valid samples in one frame -> OVERRUN=1; entry 0 is not overwritten by the 250th sample.
- UPDATE coincident with the last write in flight -> swap deferred ≤2 cycles. Both banks are verified by alternating frames with P=idx and P=255-idx.
- With PHASE_CORR_EN: offset[5]=0xF0, PHASE_IN=0x20 -> PHASE_OUT at RD_IDX=5 is 0x10.

Source files
------------

// File: rtl/stm_drive_mixer.sv
// Scales the STM per-transducer stream by a burst-latched modulation value and captures
// each burst into a ping-pong frame buffer read by index. Optional: STM_DRIVE_MIXER_PHASE_CORR_EN.
module stm_drive_mixer #(
    parameter int DEPTH       = 249,
    parameter int MOD_LATENCY = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       UPDATE,
    input  logic [7:0] MOD,
    input  logic       DIN_VALID,
    input  logic [7:0] INTENSITY_IN,
    input  logic [7:0] PHASE_IN,
    input  logic [7:0] RD_IDX,
`ifdef STM_DRIVE_MIXER_PHASE_CORR_EN
    input  logic       PC_WE,
    input  logic [7:0] PC_ADDR,
    input  logic [7:0] PC_DATA,
`endif
    output logic [7:0] INTENSITY_OUT,
    output logic [7:0] PHASE_OUT,
    output logic       OUT_READY,
    output logic       RD_BANK,
    output logic       OVERRUN,
    output logic       UNDERRUN
);

    localparam logic [8:0] DEPTH_C = 9'(DEPTH);

    logic [8:0]             wrCnt_q, wrCnt_d;
    logic                   wrBank_q, wrBank_d;
    logic                   rdBank_q, rdBank_d;
    logic                   outReady_q, outReady_d;
    logic                   overrun_q, overrun_d;
    logic                   underrun_q, underrun_d;
    logic [7:0]             modLatch_q, modLatch_d;
    logic [7:0]             intOut_q, phaseOut_q;

    logic [MOD_LATENCY-1:0] vld_q;
    logic [MOD_LATENCY-1:0] bank_q;
    logic [7:0]             s1Int_q, s1Mod_q, s1Phase_q, s1Addr_q;
    logic [7:0]             s2Scaled_q, s2Phase_q, s2Addr_q;

    logic [8:0]             cntEff;
    logic                   frameDone, swapPending, accept, oldInFlight;
    logic [7:0]             modUse;
    logic [15:0]            product;
    logic [7:0]             scaled;
    logic [7:0]             phaseS1;

    logic [15:0]            mem [0:511];

    // A bank swap is pending whenever the writer has already moved onto the bank still
    // being read; the read side follows once the closed frame's last writes have landed.
    always_comb begin
        wrCnt_d     = wrCnt_q;
        wrBank_d    = wrBank_q;
        rdBank_d    = rdBank_q;
        outReady_d  = outReady_q;
        overrun_d   = overrun_q;
        underrun_d  = underrun_q;
        modLatch_d  = modLatch_q;

        cntEff      = UPDATE ? 9'd0 : wrCnt_q;
        frameDone   = (wrCnt_q == DEPTH_C);
        swapPending = (wrBank_q == rdBank_q);

        if (UPDATE) begin
            wrCnt_d = 9'd0;
            if (!frameDone) begin
                underrun_d = 1'b1;
            end else if (!swapPending) begin
                wrBank_d = ~wrBank_q;
            end
        end

        accept = DIN_VALID && (cntEff != DEPTH_C);
        if (DIN_VALID && (cntEff == DEPTH_C)) begin
            overrun_d = 1'b1;
        end

        modUse = (cntEff == 9'd0) ? MOD : modLatch_q;
        if (accept) begin
            wrCnt_d = cntEff + 9'd1;
            if (cntEff == 9'd0) begin
                modLatch_d = MOD;
            end
        end

        oldInFlight = |(vld_q & (bank_q ^ {MOD_LATENCY{wrBank_d}}));
        if ((wrBank_d == rdBank_q) && !oldInFlight) begin
            rdBank_d   = ~rdBank_q;
            outReady_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wrCnt_q    <= 9'd0;
            wrBank_q   <= 1'b1;
            rdBank_q   <= 1'b0;
            outReady_q <= 1'b0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
            modLatch_q <= 8'd0;
        end else begin
            wrCnt_q    <= wrCnt_d;
            wrBank_q   <= wrBank_d;
            rdBank_q   <= rdBank_d;
            outReady_q <= outReady_d;
            overrun_q  <= overrun_d;
            underrun_q <= underrun_d;
            modLatch_q <= modLatch_d;
        end
    end

`ifdef STM_DRIVE_MIXER_PHASE_CORR_EN
    logic [7:0] phaseOfs [0:255];
    logic [7:0] s1Ofs_q;

    always_ff @(posedge CLK) begin
        if (PC_WE && ({1'b0, PC_ADDR} < DEPTH_C)) begin
            phaseOfs[PC_ADDR] <= PC_DATA;
        end
        s1Ofs_q <= phaseOfs[cntEff[7:0]];
    end

    assign phaseS1 = s1Phase_q + s1Ofs_q;
`else
    assign phaseS1 = s1Phase_q;
`endif

    // (p + (p>>8) + 1) >> 8 gives floor(I*M/255) exactly without a divider.
    assign product = 16'(s1Int_q) * 16'(s1Mod_q);
    assign scaled  = 8'((product + (product >> 8) + 16'd1) >> 8);

    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_q <= '0;
        end else begin
            vld_q <= {vld_q[MOD_LATENCY-2:0], accept};
        end
        bank_q     <= {bank_q[MOD_LATENCY-2:0], wrBank_d};
        s1Int_q    <= INTENSITY_IN;
        s1Phase_q  <= PHASE_IN;
        s1Mod_q    <= modUse;
        s1Addr_q   <= cntEff[7:0];
        s2Scaled_q <= scaled;
        s2Phase_q  <= phaseS1;
        s2Addr_q   <= s1Addr_q;
    end

    always_ff @(posedge CLK) begin
        if (vld_q[MOD_LATENCY-1]) begin
            mem[{bank_q[MOD_LATENCY-1], s2Addr_q}] <= {s2Scaled_q, s2Phase_q};
        end
    end

    // Reads return zero until a full frame exists and for indices past the frame.
    always_ff @(posedge CLK) begin
        if (RST) begin
            intOut_q   <= 8'd0;
            phaseOut_q <= 8'd0;
        end else if (outReady_q && ({1'b0, RD_IDX} < DEPTH_C)) begin
            {intOut_q, phaseOut_q} <= mem[{rdBank_q, RD_IDX}];
        end else begin
            intOut_q   <= 8'd0;
            phaseOut_q <= 8'd0;
        end
    end

    assign INTENSITY_OUT = intOut_q;
    assign PHASE_OUT     = phaseOut_q;
    assign OUT_READY     = outReady_q;
    assign RD_BANK       = rdBank_q;
    assign OVERRUN       = overrun_q;
    assign UNDERRUN      = underrun_q;

endmodule

// File: tb/tb_stm_drive_mixer.sv
// Directed bench for stm_drive_mixer: reset, scaling, banking, under/overrun, deferred swap.
module tb_stm_drive_mixer;

    localparam int DEPTH = 249;

    logic       CLK = 1'b0;
    logic       RST;
    logic       UPDATE;
    logic [7:0] MOD;
    logic       DIN_VALID;
    logic [7:0] INTENSITY_IN;
    logic [7:0] PHASE_IN;
    logic [7:0] RD_IDX;
    logic [7:0] INTENSITY_OUT;
    logic [7:0] PHASE_OUT;
    logic       OUT_READY;
    logic       RD_BANK;
    logic       OVERRUN;
    logic       UNDERRUN;
`ifdef STM_DRIVE_MIXER_PHASE_CORR_EN
    logic       PC_WE;
    logic [7:0] PC_ADDR;
    logic [7:0] PC_DATA;
`endif

    int   testsRun    = 0;
    int   testsFailed = 0;
    logic expBank;

    stm_drive_mixer #(.DEPTH(DEPTH), .MOD_LATENCY(2)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .UPDATE       (UPDATE),
        .MOD          (MOD),
        .DIN_VALID    (DIN_VALID),
        .INTENSITY_IN (INTENSITY_IN),
        .PHASE_IN     (PHASE_IN),
        .RD_IDX       (RD_IDX),
`ifdef STM_DRIVE_MIXER_PHASE_CORR_EN
        .PC_WE        (PC_WE),
        .PC_ADDR      (PC_ADDR),
        .PC_DATA      (PC_DATA),
`endif
        .INTENSITY_OUT(INTENSITY_OUT),
        .PHASE_OUT    (PHASE_OUT),
        .OUT_READY    (OUT_READY),
        .RD_BANK      (RD_BANK),
        .OVERRUN      (OVERRUN),
        .UNDERRUN     (UNDERRUN)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulseUpdate();
        UPDATE = 1'b1;
        tick();
        UPDATE = 1'b0;
    endtask

    task automatic doReset();
        RST = 1'b1;
        idle(2);
        RST = 1'b0;
        tick();
    endtask

    function automatic logic [7:0] phaseOf(input int i, input int mode);
        logic [7:0] idx;
        idx = i[7:0];
        case (mode)
            0:       return idx;
            1:       return 8'd255 - idx;
            2:       return idx ^ 8'h5A;
            default: return 8'h20;
        endcase
    endfunction

    task automatic applyStimulus(input int n, input logic [7:0] inten,
                                 input logic [7:0] modFirst, input logic [7:0] modRest,
                                 input int phaseMode);
        for (int i = 0; i < n; i++) begin
            DIN_VALID    = 1'b1;
            INTENSITY_IN = inten;
            MOD          = (i == 0) ? modFirst : modRest;
            PHASE_IN     = phaseOf(i, phaseMode);
            tick();
        end
        DIN_VALID = 1'b0;
        MOD       = 8'd0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        idle(2);
        testsRun++; if (INTENSITY_OUT !== 8'd0) begin testsFailed++; $display("[TB] FAIL reset_int: got %0d expected 0", INTENSITY_OUT); end
        testsRun++; if (PHASE_OUT !== 8'd0) begin testsFailed++; $display("[TB] FAIL reset_phase: got %0d expected 0", PHASE_OUT); end
        testsRun++; if (OUT_READY !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_ready: got %b expected 0", OUT_READY); end
        testsRun++; if (RD_BANK !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_bank: got %b expected 0", RD_BANK); end
        testsRun++; if (OVERRUN !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_overrun: got %b expected 0", OVERRUN); end
        testsRun++; if (UNDERRUN !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_underrun: got %b expected 0", UNDERRUN); end
        RST = 1'b0;
        tick();
        expBank = 1'b0;
    endtask

    task automatic test_underrun_no_prior();
        applyStimulus(100, 8'd255, 8'd255, 8'd255, 0);
        idle(3);
        pulseUpdate();
        testsRun++; if (UNDERRUN !== 1'b1) begin testsFailed++; $display("[TB] FAIL underrun0_flag: got %b expected 1", UNDERRUN); end
        testsRun++; if (OUT_READY !== 1'b0) begin testsFailed++; $display("[TB] FAIL underrun0_ready: got %b expected 0", OUT_READY); end
        testsRun++; if (RD_BANK !== 1'b0) begin testsFailed++; $display("[TB] FAIL underrun0_bank: got %b expected 0", RD_BANK); end
        RD_IDX = 8'd10;
        tick();
        testsRun++; if (INTENSITY_OUT !== 8'd0) begin testsFailed++; $display("[TB] FAIL underrun0_forced0: got %0d expected 0", INTENSITY_OUT); end
    endtask

    task automatic test_full_frame();
        applyStimulus(DEPTH, 8'd255, 8'd255, 8'd255, 0);
        idle(3);
        pulseUpdate();
        expBank = ~expBank;
        testsRun++; if (OUT_READY !== 1'b1) begin testsFailed++; $display("[TB] FAIL full_ready: got %b expected 1", OUT_READY); end
        testsRun++; if (RD_BANK !== 1'b1) begin testsFailed++; $display("[TB] FAIL full_bank: got %b expected 1", RD_BANK); end
        RD_IDX = 8'd10;
        tick();
        testsRun++; if (INTENSITY_OUT !== 8'd255) begin testsFailed++; $display("[TB] FAIL full_int10: got %0d expected 255", INTENSITY_OUT); end
        testsRun++; if (PHASE_OUT !== 8'd10) begin testsFailed++; $display("[TB] FAIL full_phase10: got %0d expected 10", PHASE_OUT); end
        testsRun++; if (UNDERRUN !== 1'b0 || OVERRUN !== 1'b0) begin testsFailed++; $display("[TB] FAIL full_flags: got %b%b expected 00", UNDERRUN, OVERRUN); end
    endtask

    task automatic test_mod_latch();
        int idxList[4] = '{0, 1, 100, 248};
        applyStimulus(DEPTH, 8'd200, 8'd128, 8'd0, 0);
        idle(3);
        pulseUpdate();
        expBank = ~expBank;
        testsRun++; if (RD_BANK !== expBank) begin testsFailed++; $display("[TB] FAIL mod_bank: got %b expected %b", RD_BANK, expBank); end
        foreach (idxList[k]) begin
            RD_IDX = 8'(idxList[k]);
            tick();
            testsRun++; if (INTENSITY_OUT !== 8'd100) begin testsFailed++; $display("[TB] FAIL mod_int idx %0d: got %0d expected 100", idxList[k], INTENSITY_OUT); end
            testsRun++; if (PHASE_OUT !== 8'(idxList[k])) begin testsFailed++; $display("[TB] FAIL mod_phase idx %0d: got %0d expected %0d", idxList[k], PHASE_OUT, idxList[k]); end
        end
        RD_IDX = 8'd249;
        tick();
        testsRun++; if (INTENSITY_OUT !== 8'd0 || PHASE_OUT !== 8'd0) begin testsFailed++; $display("[TB] FAIL mod_oob: got %0d/%0d expected 0/0", INTENSITY_OUT, PHASE_OUT); end
    endtask

    task automatic test_back_to_back();
        logic oldBank;
        applyStimulus(DEPTH, 8'd255, 8'd255, 8'd255, 0);
        RD_IDX  = 8'd248;
        oldBank = expBank;
        for (int i = 0; i < DEPTH; i++) begin
            UPDATE       = (i == 0);
            DIN_VALID    = 1'b1;
            INTENSITY_IN = 8'd255;
            MOD          = 8'd255;
            PHASE_IN     = phaseOf(i, 1);
            tick();
            if (i == 0) begin
                testsRun++; if (RD_BANK !== oldBank) begin testsFailed++; $display("[TB] FAIL b2b_deferred: got %b expected %b", RD_BANK, oldBank); end
            end
            if (i == 2) begin
                testsRun++; if (RD_BANK !== ~oldBank) begin testsFailed++; $display("[TB] FAIL b2b_swap_bound: got %b expected %b", RD_BANK, ~oldBank); end
            end
            if (i == 4) begin
                testsRun++; if (PHASE_OUT !== 8'd248) begin testsFailed++; $display("[TB] FAIL b2b_lastA_phase: got %0d expected 248", PHASE_OUT); end
                testsRun++; if (INTENSITY_OUT !== 8'd255) begin testsFailed++; $display("[TB] FAIL b2b_lastA_int: got %0d expected 255", INTENSITY_OUT); end
            end
        end
        UPDATE    = 1'b0;
        DIN_VALID = 1'b0;
        expBank   = ~oldBank;
        idle(3);
        pulseUpdate();
        expBank = ~expBank;
        testsRun++; if (RD_BANK !== expBank) begin testsFailed++; $display("[TB] FAIL b2b_bankB: got %b expected %b", RD_BANK, expBank); end
        testsRun++; if (UNDERRUN !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_underrun: got %b expected 0", UNDERRUN); end
        RD_IDX = 8'd0;
        tick();
        testsRun++; if (PHASE_OUT !== 8'd255) begin testsFailed++; $display("[TB] FAIL b2b_B0_phase: got %0d expected 255", PHASE_OUT); end
        RD_IDX = 8'd248;
        tick();
        testsRun++; if (PHASE_OUT !== 8'd7) begin testsFailed++; $display("[TB] FAIL b2b_B248_phase: got %0d expected 7", PHASE_OUT); end
    endtask

    task automatic test_overrun();
        applyStimulus(DEPTH, 8'd255, 8'd255, 8'd255, 2);
        DIN_VALID    = 1'b1;
        INTENSITY_IN = 8'd3;
        PHASE_IN     = 8'h77;
        tick();
        DIN_VALID = 1'b0;
        tick();
        testsRun++; if (OVERRUN !== 1'b1) begin testsFailed++; $display("[TB] FAIL overrun_flag: got %b expected 1", OVERRUN); end
        idle(2);
        pulseUpdate();
        expBank = ~expBank;
        testsRun++; if (RD_BANK !== expBank) begin testsFailed++; $display("[TB] FAIL overrun_bank: got %b expected %b", RD_BANK, expBank); end
        RD_IDX = 8'd0;
        tick();
        testsRun++; if (PHASE_OUT !== 8'h5A) begin testsFailed++; $display("[TB] FAIL overrun_entry0_phase: got %0h expected 5a", PHASE_OUT); end
        testsRun++; if (INTENSITY_OUT !== 8'd255) begin testsFailed++; $display("[TB] FAIL overrun_entry0_int: got %0d expected 255", INTENSITY_OUT); end
        RD_IDX = 8'd248;
        tick();
        testsRun++; if (PHASE_OUT !== 8'hA2) begin testsFailed++; $display("[TB] FAIL overrun_entry248_phase: got %0h expected a2", PHASE_OUT); end
    endtask

    task automatic test_underrun_with_prior();
        applyStimulus(100, 8'd50, 8'd255, 8'd255, 0);
        idle(3);
        pulseUpdate();
        testsRun++; if (UNDERRUN !== 1'b1) begin testsFailed++; $display("[TB] FAIL underrun1_flag: got %b expected 1", UNDERRUN); end
        testsRun++; if (RD_BANK !== expBank) begin testsFailed++; $display("[TB] FAIL underrun1_bank: got %b expected %b", RD_BANK, expBank); end
        testsRun++; if (OUT_READY !== 1'b1) begin testsFailed++; $display("[TB] FAIL underrun1_ready: got %b expected 1", OUT_READY); end
        RD_IDX = 8'd0;
        tick();
        testsRun++; if (PHASE_OUT !== 8'h5A) begin testsFailed++; $display("[TB] FAIL underrun1_frame_kept: got %0h expected 5a", PHASE_OUT); end
    endtask

`ifdef STM_DRIVE_MIXER_PHASE_CORR_EN
    task automatic initPhaseTable();
        for (int i = 0; i < DEPTH; i++) begin
            PC_WE   = 1'b1;
            PC_ADDR = 8'(i);
            PC_DATA = 8'd0;
            tick();
        end
        PC_WE = 1'b0;
    endtask

    task automatic test_phase_corr();
        PC_WE   = 1'b1;
        PC_ADDR = 8'd5;
        PC_DATA = 8'hF0;
        tick();
        PC_WE = 1'b0;
        applyStimulus(DEPTH, 8'd255, 8'd255, 8'd255, 3);
        idle(3);
        pulseUpdate();
        expBank = ~expBank;
        RD_IDX  = 8'd5;
        tick();
        testsRun++; if (PHASE_OUT !== 8'h10) begin testsFailed++; $display("[TB] FAIL pc_phase5: got %0h expected 10", PHASE_OUT); end
        RD_IDX = 8'd6;
        tick();
        testsRun++; if (PHASE_OUT !== 8'h20) begin testsFailed++; $display("[TB] FAIL pc_phase6: got %0h expected 20", PHASE_OUT); end
    endtask
`endif

    initial begin
        RST          = 1'b1;
        UPDATE       = 1'b0;
        MOD          = 8'd0;
        DIN_VALID    = 1'b0;
        INTENSITY_IN = 8'd0;
        PHASE_IN     = 8'd0;
        RD_IDX       = 8'd0;
        expBank      = 1'b0;
`ifdef STM_DRIVE_MIXER_PHASE_CORR_EN
        PC_WE   = 1'b0;
        PC_ADDR = 8'd0;
        PC_DATA = 8'd0;
`endif
        test_reset();
        test_underrun_no_prior();
        doReset();
        expBank = 1'b0;
`ifdef STM_DRIVE_MIXER_PHASE_CORR_EN
        initPhaseTable();
`endif
        test_full_frame();
        test_mod_latch();
        test_back_to_back();
        test_overrun();
        test_underrun_with_prior();
`ifdef STM_DRIVE_MIXER_PHASE_CORR_EN
        test_phase_corr();
`endif
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
